// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//  Producer side of the register-file write port. Each cycle it picks at most
//  one result: a single-cycle ALU result has priority. Otherwise the oldest
//  long-latency LSU/muldiv result, held in a small in-order FIFO, is used.
//  The chosen result is registered onto rd/wb/wb_sig. A scoreboard of
//  outstanding long-latency destinations produces the decode hazard flags.
//
//  Optional feature macro: WB_BYPASS_EN
//    defined   : decode may forward from the output register (fwdN_*); a
//                hazard on an LSU result sitting in the output register is
//                masked while it is forwardable.
//    undefined : fwdN_* tied low; hazards come from the scoreboard only.
// ---------------------------------------------------------------------------
module wb_arbiter #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            cpu_clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            hz1,
    output logic            hz2,
    output logic            fwd1_valid,
    output logic            fwd2_valid,
    output logic [XLEN-1:0] fwd1_data,
    output logic [XLEN-1:0] fwd2_data,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] wb,
    output logic            wb_sig
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Origin of the value held in the output register.
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_t;

    // LSU result FIFO storage and bookkeeping
    logic [4:0]      fifo_rd_r   [DEPTH];
    logic [XLEN-1:0] fifo_data_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;

    // Output register
    logic [4:0]      rd_r;
    logic [XLEN-1:0] wb_r;
    logic            wb_sig_r;
    src_t            src_r;

    // Scoreboard of pending long-latency destinations
    logic [31:0]     busy_r;
    logic [31:0]     busy_next_s;

    // Per-cycle decisions
    logic            lsu_ready_s;
    logic            push_s;
    logic            pop_s;
    logic            alu_sel_s;
    logic            commit_s;
    logic [4:0]      head_rd_s;
    logic [XLEN-1:0] head_data_s;

    // Ready depends only on the registered occupancy, so a pop in the same
    // cycle never opens a slot early.
    assign lsu_ready_s = (count_r < CW'(DEPTH));
    assign push_s      = lsu_valid & lsu_ready_s;

    // ALU writes to x0 are treated as idle so the FIFO can drain behind them.
    assign alu_sel_s   = ~stall & alu_valid & (alu_rd != 5'd0);
    assign pop_s       = ~stall & ~alu_sel_s & (count_r != {CW{1'b0}});
    assign commit_s    = wb_sig_r & ~stall;

    assign head_rd_s   = fifo_rd_r[rd_ptr_r];
    assign head_data_s = fifo_data_r[rd_ptr_r];

    // FIFO storage: write the incoming LSU result at the tail on a push.
    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_rd_r[i]   <= 5'd0;
                fifo_data_r[i] <= {XLEN{1'b0}};
            end
        end else if (push_s) begin
            fifo_rd_r[wr_ptr_r]   <= lsu_rd;
            fifo_data_r[wr_ptr_r] <= lsu_data;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count as is.
    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Output register: ALU first, then FIFO head; everything holds under stall.
    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_r     <= 5'd0;
            wb_r     <= {XLEN{1'b0}};
            wb_sig_r <= 1'b0;
            src_r    <= SRC_ALU;
        end else if (!stall) begin
            if (alu_sel_s) begin
                rd_r     <= alu_rd;
                wb_r     <= alu_data;
                wb_sig_r <= 1'b1;
                src_r    <= SRC_ALU;
            end else if (pop_s) begin
                // A popped x0 result occupies the slot but never writes.
                rd_r     <= head_rd_s;
                wb_r     <= head_data_s;
                wb_sig_r <= (head_rd_s != 5'd0);
                src_r    <= SRC_LSU;
            end else begin
                wb_sig_r <= 1'b0;
            end
        end
    end

    // Scoreboard next state: clear on an LSU-sourced commit, then set on
    // issue so a same-index set overrides the clear.
    always_comb begin
        busy_next_s = busy_r;
        if (commit_s && (src_r == SRC_LSU) && (rd_r != 5'd0)) begin
            busy_next_s[rd_r] = 1'b0;
        end else begin
            busy_next_s = busy_next_s;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            busy_next_s[issue_rd] = 1'b1;
        end else begin
            busy_next_s = busy_next_s;
        end
        busy_next_s[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 32'd0;
        end else begin
            busy_r <= busy_next_s;
        end
    end

    // Decode hazard and forwarding flags.
    always_comb begin
        hz1        = 1'b0;
        hz2        = 1'b0;
        fwd1_valid = 1'b0;
        fwd2_valid = 1'b0;
        fwd1_data  = {XLEN{1'b0}};
        fwd2_data  = {XLEN{1'b0}};
`ifdef WB_BYPASS_EN
        fwd1_valid = wb_sig_r & (rd_r != 5'd0) & (rd_r == rs1);
        fwd2_valid = wb_sig_r & (rd_r != 5'd0) & (rd_r == rs2);
        fwd1_data  = wb_r;
        fwd2_data  = wb_r;
        hz1 = (rs1 != 5'd0) & busy_r[rs1] & ~(fwd1_valid & (src_r == SRC_LSU));
        hz2 = (rs2 != 5'd0) & busy_r[rs2] & ~(fwd2_valid & (src_r == SRC_LSU));
`else
        hz1 = (rs1 != 5'd0) & busy_r[rs1];
        hz2 = (rs2 != 5'd0) & busy_r[rs2];
`endif
    end

    assign lsu_ready = lsu_ready_s;
    assign rd        = rd_r;
    assign wb        = wb_r;
    assign wb_sig    = wb_sig_r;

endmodule

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter
//  Directed vector table for wb_arbiter plus hand-written sequences for the
//  scoreboard/stall, set-versus-clear and asynchronous-reset corner cases.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_arbiter;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        cpu_clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        hz1;
    logic        hz2;
    logic        fwd1_valid;
    logic        fwd2_valid;
    logic [31:0] fwd1_data;
    logic [31:0] fwd2_data;
    logic [4:0]  rd;
    logic [31:0] wb;
    logic        wb_sig;

    int checks = 0;
    int errors = 0;

    wb_arbiter #(.XLEN(32), .DEPTH(4)) dut (
        .cpu_clk(cpu_clk), .rst_n(rst_n), .stall(stall),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
        .hz1(hz1), .hz2(hz2), .fwd1_valid(fwd1_valid), .fwd2_valid(fwd2_valid),
        .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
        .rd(rd), .wb(wb), .wb_sig(wb_sig)
    );

    // Free-running clock.
    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic        stall;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldat;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  e_rd;
        logic [31:0] e_wb;
        logic        e_ws;
        logic        e_rdy;
        logic        e_hz1;
        logic        e_hz2;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input logic av, input logic [4:0] ard,
                                input logic [31:0] adat, input logic lv, input logic [4:0] lrd,
                                input logic [31:0] ldat, input logic iv, input logic [4:0] ird,
                                input logic [4:0] r1, input logic [4:0] r2,
                                input logic [4:0] e_rd, input logic [31:0] e_wb, input logic e_ws,
                                input logic e_rdy, input logic e_hz1, input logic e_hz2);
        vec_t v;
        v.stall = s;  v.av = av;   v.ard = ard; v.adat = adat;
        v.lv = lv;    v.lrd = lrd; v.ldat = ldat;
        v.iv = iv;    v.ird = ird; v.r1 = r1;   v.r2 = r2;
        v.e_rd = e_rd; v.e_wb = e_wb; v.e_ws = e_ws;
        v.e_rdy = e_rdy; v.e_hz1 = e_hz1; v.e_hz2 = e_hz2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        stall = 1'b0; alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
        issue_valid = 1'b0; issue_rd = 5'd0;
    endtask

    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    // Output-register check; rd/wb only matter while a write is signalled.
    task automatic chk_out(input string tag, input logic [4:0] e_rd, input logic [31:0] e_wb,
                           input logic e_ws);
        chk({tag, " wb_sig"}, {31'd0, wb_sig}, {31'd0, e_ws});
        if (e_ws) begin
            chk({tag, " rd"}, {27'd0, rd}, {27'd0, e_rd});
            chk({tag, " wb"}, wb, e_wb);
        end
    endtask

    initial begin
        // Vector table: inputs applied, one clock edge, then outputs compared.
        //          s  av ard   adat          lv lrd    ldat          iv ird    r1     r2     e_rd   e_wb          ws rdy h1 h2
        vecs.push_back(mk(0, 1, 5'd5, 32'h1234, 0, 5'd0, 32'h0,    0, 5'd0, 5'd0, 5'd0, 5'd5, 32'h1234, 1, 1, 0, 0)); // ALU basic
        vecs.push_back(mk(0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 5'd0, 5'd0, 5'd0, 5'd5, 32'h1234, 0, 1, 0, 0)); // idle
        vecs.push_back(mk(0, 1, 5'd3, 32'hA,    1, 5'd7, 32'hB,    0, 5'd0, 5'd0, 5'd0, 5'd3, 32'hA,    1, 1, 0, 0)); // collision
        vecs.push_back(mk(0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 5'd0, 5'd0, 5'd0, 5'd7, 32'hB,    1, 1, 0, 0)); // LSU next
        vecs.push_back(mk(0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 5'd0, 5'd0, 5'd0, 5'd7, 32'hB,    0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 5'd1, 32'h100,  1, 5'd11, 32'h11,  0, 5'd0, 5'd0, 5'd0, 5'd1, 32'h100,  1, 1, 0, 0)); // fill
        vecs.push_back(mk(0, 1, 5'd1, 32'h101,  1, 5'd12, 32'h12,  0, 5'd0, 5'd0, 5'd0, 5'd1, 32'h101,  1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 5'd1, 32'h102,  1, 5'd13, 32'h13,  0, 5'd0, 5'd0, 5'd0, 5'd1, 32'h102,  1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 5'd1, 32'h103,  1, 5'd14, 32'h14,  0, 5'd0, 5'd0, 5'd0, 5'd1, 32'h103,  1, 0, 0, 0)); // full
        vecs.push_back(mk(0, 1, 5'd1, 32'h104,  1, 5'd15, 32'h15,  0, 5'd0, 5'd0, 5'd0, 5'd1, 32'h104,  1, 0, 0, 0)); // refused push
        vecs.push_back(mk(0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 5'd0, 5'd0, 5'd0, 5'd11, 32'h11,  1, 1, 0, 0)); // drain
        vecs.push_back(mk(0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 5'd0, 5'd0, 5'd0, 5'd12, 32'h12,  1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 5'd0, 5'd0, 5'd0, 5'd13, 32'h13,  1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 5'd0, 5'd0, 5'd0, 5'd14, 32'h14,  1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 5'd2, 32'h200,  0, 5'd0, 32'h0,    0, 5'd0, 5'd0, 5'd0, 5'd2, 32'h200,  1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 5'd4, 32'h400,  1, 5'd6, 32'h66,   0, 5'd0, 5'd0, 5'd0, 5'd2, 32'h200,  1, 1, 0, 0)); // stall holds, push ok
        vecs.push_back(mk(0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 5'd0, 5'd0, 5'd0, 5'd6, 32'h66,   1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 5'd0, 5'd0, 5'd0, 5'd6, 32'h66,   0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 5'd0, 32'h55,   1, 5'd0, 32'h77,   0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0,    0, 1, 0, 0)); // x0 both
        vecs.push_back(mk(0, 1, 5'd0, 32'h56,   0, 5'd0, 32'h0,    0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0,    0, 1, 0, 0)); // x0 popped
        vecs.push_back(mk(0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0,    0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    1, 5'd9, 5'd9, 5'd10, 5'd0, 32'h0,   0, 1, 1, 0)); // issue 9
        vecs.push_back(mk(0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    1, 5'd10, 5'd9, 5'd10, 5'd0, 32'h0,  0, 1, 1, 1)); // issue 10
        vecs.push_back(mk(0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    1, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0,    0, 1, 0, 0)); // x0 never busy
        vecs.push_back(mk(0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 5'd0, 5'd9, 5'd10, 5'd0, 32'h0,   0, 1, 1, 1));

        // Reset state
        idle_inputs();
        rs1 = 5'd0; rs2 = 5'd0;
        rst_n = 1'b0;
        repeat (2) @(posedge cpu_clk);
        #1;
        chk("reset wb_sig", {31'd0, wb_sig}, 32'd0);
        chk("reset rd", {27'd0, rd}, 32'd0);
        chk("reset wb", wb, 32'd0);
        chk("reset lsu_ready", {31'd0, lsu_ready}, 32'd1);
        chk("reset fwd1_valid", {31'd0, fwd1_valid}, 32'd0);
        @(negedge cpu_clk);
        rst_n = 1'b1;
        @(posedge cpu_clk);
        #1;

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            stall = vecs[i].stall; alu_valid = vecs[i].av; alu_rd = vecs[i].ard;
            alu_data = vecs[i].adat; lsu_valid = vecs[i].lv; lsu_rd = vecs[i].lrd;
            lsu_data = vecs[i].ldat; issue_valid = vecs[i].iv; issue_rd = vecs[i].ird;
            rs1 = vecs[i].r1; rs2 = vecs[i].r2;
            step();
            chk_out($sformatf("v%0d", i), vecs[i].e_rd, vecs[i].e_wb, vecs[i].e_ws);
            chk($sformatf("v%0d lsu_ready", i), {31'd0, lsu_ready}, {31'd0, vecs[i].e_rdy});
            chk($sformatf("v%0d hz1", i), {31'd0, hz1}, {31'd0, vecs[i].e_hz1});
            chk($sformatf("v%0d hz2", i), {31'd0, hz2}, {31'd0, vecs[i].e_hz2});
        end

        // Scoreboard with LSU result held in the output register under stall.
        // busy[9] and busy[10] are set here.
        idle_inputs();
        rs1 = 5'd9; rs2 = 5'd10;
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
        step();
        chk_out("sb push", 5'd0, 32'd0, 1'b0);
        chk("sb push hz1", {31'd0, hz1}, 32'd1);
        idle_inputs();
        step();
        chk_out("sb out", 5'd9, 32'h99, 1'b1);
        chk("sb out hz1", {31'd0, hz1}, BYP ? 32'd0 : 32'd1);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_out($sformatf("sb stall%0d", k), 5'd9, 32'h99, 1'b1);
            chk($sformatf("sb stall%0d hz1", k), {31'd0, hz1}, BYP ? 32'd0 : 32'd1);
            chk($sformatf("sb stall%0d fwd1_valid", k), {31'd0, fwd1_valid}, BYP ? 32'd1 : 32'd0);
            chk($sformatf("sb stall%0d fwd1_data", k), fwd1_data, BYP ? 32'h99 : 32'd0);
            chk($sformatf("sb stall%0d hz2", k), {31'd0, hz2}, 32'd1);
        end
        stall = 1'b0;
        step();
        chk_out("sb commit", 5'd0, 32'd0, 1'b0);
        chk("sb commit hz1", {31'd0, hz1}, 32'd0);
        chk("sb commit hz2", {31'd0, hz2}, 32'd1);

        // Same-index set and clear in one cycle: the set survives.
        lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'hA0;
        step();
        idle_inputs();
        step();
        chk_out("sw out", 5'd10, 32'hA0, 1'b1);
        issue_valid = 1'b1; issue_rd = 5'd10;
        step();
        idle_inputs();
        chk("sw setwins hz2", {31'd0, hz2}, 32'd1);
        lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'hA1;
        step();
        idle_inputs();
        step();
        step();
        chk("sw cleared hz2", {31'd0, hz2}, 32'd0);

        // Asynchronous reset in the middle of a burst.
        rs1 = 5'd20; rs2 = 5'd0;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_data = 32'h20;
        issue_valid = 1'b1; issue_rd = 5'd20;
        step();
        chk_out("rst pre", 5'd3, 32'h33, 1'b1);
        chk("rst pre hz1", {31'd0, hz1}, 32'd1);
        issue_valid = 1'b0;
        alu_data = 32'h34; lsu_rd = 5'd21; lsu_data = 32'h21;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst async wb_sig", {31'd0, wb_sig}, 32'd0);
        chk("rst async lsu_ready", {31'd0, lsu_ready}, 32'd1);
        chk("rst async hz1", {31'd0, hz1}, 32'd0);
        chk("rst async rd", {27'd0, rd}, 32'd0);
        idle_inputs();
        @(negedge cpu_clk);
        rst_n = 1'b1;
        step();
        chk("rst post wb_sig0", {31'd0, wb_sig}, 32'd0);
        step();
        chk("rst post wb_sig1", {31'd0, wb_sig}, 32'd0);
        chk("rst post lsu_ready", {31'd0, lsu_ready}, 32'd1);
        chk("rst post hz1", {31'd0, hz1}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
